rll_frame_ctrl: RTL and testbench

Frame scheduler and arbiter in front of the bit-serial RLL(2,7) coder. Two byte-stream requesters share the single coder; the block grants one at a time round-robin, wraps the payload in a sync byte, a length byte and a zero flush tail, and streams the frame MSB-first to the coder's bit input under a valid/ready handshake. It owns all sequencing, so the coder only ever sees well-formed frames that end on a codeword boundary.

---
 rtl/rll_pkg.sv | 23 ++
 rtl/rll_rr_arbiter.sv | 43 ++++
 rtl/rll_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_rll_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_pkg.sv
// Shared types and defaults for the RLL(2,7) frame controller.
package rll_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StLen,
    StPayload,
    StPad,
    StDone
  } rll_state_e;

  localparam logic [7:0]  SyncByteDefault = 8'hA1;
  localparam int unsigned PadBitsDefault  = 4;

  // Frames go out MSB-first, so the coder bit is always taken from this end of the shifter.
  localparam int unsigned MsbIdx = 7;

  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/rll_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the request vector, starting the search at the pointer.
module rll_rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  input  logic [IW-1:0]   served,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = IW'((32'(ptr_q) + off) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  // The requester just served drops to lowest priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (update) begin
      ptr_q <= (served == IW'(NREQ - 1)) ? '0 : served + IW'(1);
    end
  end

endmodule

// File: rtl/rll_frame_ctrl.sv
// Frame scheduler for the bit-serial RLL(2,7) coder: arbitrates two byte streams and emits
// sync + length + payload + zero tail MSB-first under a valid/ready handshake.
module rll_frame_ctrl
  import rll_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned LW        = len_width(MAX_LEN),
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault,
  parameter int unsigned PAD_BITS  = PadBitsDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*LW-1:0] req_len,
  input  logic [NREQ*8-1:0]  req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    data_rd,
  output logic               enc_bit,
  output logic               enc_valid,
  input  logic               enc_ready,
  output logic               busy,
  output logic               done,
  output logic [7:0]         frame_cnt
);

  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BCW = 3;

  localparam logic [BCW-1:0] LastDataBit = BCW'(7);
  localparam logic [BCW-1:0] LastPadBit  = BCW'(PAD_BITS - 1);
  localparam logic [LW-1:0]  MaxLen      = LW'(MAX_LEN);

  rll_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   gnt_idx_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   byte_cnt_q;
  logic [BCW-1:0]  bit_cnt_q;
  logic [7:0]      shift_q;
  logic            enc_valid_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      frame_cnt_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic [LW-1:0]   arb_len_raw;
  logic [LW-1:0]   start_len;
  logic [7:0]      cur_data;
  logic            xfer;
  logic            byte_end;
  logic            more;
  logic            pop;

  rll_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .update  (state_q == StDone),
    .served  (gnt_idx_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign arb_len_raw = req_len[arb_idx*LW +: LW];
  assign start_len   = (arb_len_raw > MaxLen) ? MaxLen : arb_len_raw;
  assign cur_data    = req_data[gnt_idx_q*8 +: 8];

  assign xfer     = enc_valid_q & enc_ready;
  assign byte_end = xfer & (bit_cnt_q == LastDataBit);
  assign more     = byte_cnt_q < len_q;

  // Pop in the same cycle whose edge loads the head byte into the shifter.
  assign pop = byte_end & (((state_q == StLen) & (len_q != '0)) |
                           ((state_q == StPayload) & more));

  assign data_rd   = pop ? gnt_q : '0;
  assign gnt       = gnt_q;
  assign enc_bit   = shift_q[MsbIdx];
  assign enc_valid = enc_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      enc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            gnt_q       <= arb_gnt;
            gnt_idx_q   <= arb_idx;
            len_q       <= start_len;
            shift_q     <= SYNC_BYTE;
            bit_cnt_q   <= '0;
            enc_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StSync;
          end
        end
        StSync: begin
          if (byte_end) begin
            shift_q   <= 8'(len_q);
            bit_cnt_q <= '0;
            state_q   <= StLen;
          end else if (xfer) begin
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        StLen: begin
          if (byte_end) begin
            bit_cnt_q <= '0;
            if (len_q == '0) begin
              shift_q <= '0;
              state_q <= StPad;
            end else begin
              shift_q    <= cur_data;
              byte_cnt_q <= LW'(1);
              state_q    <= StPayload;
            end
          end else if (xfer) begin
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        StPayload: begin
          if (byte_end) begin
            bit_cnt_q <= '0;
            if (more) begin
              shift_q    <= cur_data;
              byte_cnt_q <= byte_cnt_q + LW'(1);
            end else begin
              shift_q <= '0;
              state_q <= StPad;
            end
          end else if (xfer) begin
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        StPad: begin
          if (xfer) begin
            if (bit_cnt_q == LastPadBit) begin
              enc_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        StDone: begin
          gnt_q       <= '0;
          busy_q      <= 1'b0;
          frame_cnt_q <= frame_cnt_q + 8'd1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rll_frame_ctrl.sv
// Bench for rll_frame_ctrl: frame-level reference model, requester queues and a bit-stream monitor.
module tb_rll_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [4:0] lc0 = 5'd0;
  logic [4:0] lc1 = 5'd0;
  logic       enc_ready = 1'b1;
  logic [9:0] req_len;
  logic [15:0] req_data;
  logic [1:0] gnt;
  logic [1:0] data_rd;
  logic       enc_bit;
  logic       enc_valid;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] rd_ptr0 = 8'd0;
  logic [7:0] rd_ptr1 = 8'd0;
  int         pops0 = 0;
  int         pops1 = 0;

  bit         got_q[$];
  logic [1:0] gnt_done_q[$];
  int         gap_q[$];
  int         run_q[$];
  int         done_cnt = 0;
  int         low_run = 0;
  int         high_run = 0;
  int         stall_bad = 0;
  int         rd_stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic       prev_bit = 1'b0;

  int         checks = 0;
  int         failures = 0;
  int         rr_ptr = 0;
  logic [7:0] exp_frames = 8'd0;
  bit         exp_q[$];
  int         last_base = 0;

  assign req_len  = {lc1, lc0};
  assign req_data = {mem1[rd_ptr1], mem0[rd_ptr0]};

  always #5 clk = ~clk;

  rll_frame_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_len   (req_len),
    .req_data  (req_data),
    .gnt       (gnt),
    .data_rd   (data_rd),
    .enc_bit   (enc_bit),
    .enc_valid (enc_valid),
    .enc_ready (enc_ready),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  // Requesters advance their head byte on the edge that sees the pop strobe.
  always @(posedge clk) begin
    if (data_rd[0]) begin
      rd_ptr0 <= rd_ptr0 + 8'd1;
      pops0   <= pops0 + 1;
    end
    if (data_rd[1]) begin
      rd_ptr1 <= rd_ptr1 + 8'd1;
      pops1   <= pops1 + 1;
    end
  end

  always @(negedge clk) begin
    if (enc_valid && enc_ready) got_q.push_back(enc_bit);
    if (done) begin
      done_cnt <= done_cnt + 1;
      gnt_done_q.push_back(gnt);
    end
    if (enc_valid) begin
      if (low_run > 0) gap_q.push_back(low_run);
      low_run  <= 0;
      high_run <= high_run + 1;
    end else begin
      if (high_run > 0) run_q.push_back(high_run);
      high_run <= 0;
      low_run  <= low_run + 1;
    end
    if (prev_stall && rst_n && (!enc_valid || enc_bit !== prev_bit)) stall_bad <= stall_bad + 1;
    if (data_rd != 2'b00 && !enc_ready) rd_stall_bad <= rd_stall_bad + 1;
    prev_stall <= enc_valid && !enc_ready;
    prev_bit   <= enc_bit;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  // Runs nframes frames with req held at mask and compares against the frame-level model.
  task automatic frame_test(input logic [1:0] mask, input int nframes, input bit throttle,
                            input bit fill, input string tag);
    int         win[$];
    int         runlen[$];
    logic [7:0] ep0, ep1;
    int         e_pops0, e_pops1, w, len, base, dn0, gb, gpb, rb, p0, p1;
    int         budget, cyc, mism;
    if (fill) begin
      for (int k = 0; k < 64; k++) begin
        mem0[rd_ptr0 + 8'(k)] = 8'($urandom);
        mem1[rd_ptr1 + 8'(k)] = 8'($urandom);
      end
    end
    ep0 = rd_ptr0; ep1 = rd_ptr1; p0 = pops0; p1 = pops1;
    base = got_q.size(); last_base = base; dn0 = done_cnt;
    gb = gnt_done_q.size(); gpb = gap_q.size(); rb = run_q.size();
    exp_q.delete();
    e_pops0 = 0; e_pops1 = 0;
    for (int f = 0; f < nframes; f++) begin
      w   = (mask == 2'b11) ? rr_ptr : (mask[1] ? 1 : 0);
      len = w ? int'(lc1) : int'(lc0);
      if (len > 16) len = 16;
      win.push_back(w);
      runlen.push_back(16 + 8 * len + 4);
      push_byte(8'hA1);
      push_byte(8'(len));
      for (int j = 0; j < len; j++) begin
        if (w == 1) begin
          push_byte(mem1[ep1]); ep1 = ep1 + 8'd1; e_pops1++;
        end else begin
          push_byte(mem0[ep0]); ep0 = ep0 + 8'd1; e_pops0++;
        end
      end
      for (int j = 0; j < 4; j++) exp_q.push_back(1'b0);
      rr_ptr = 1 - w;
    end
    exp_frames = exp_frames + 8'(nframes);

    req = mask;
    tick();
    chk({tag, "_gnt_first"}, 32'(gnt), 32'(1 << win[0]));
    chk({tag, "_valid_first"}, 32'(enc_valid), 32'd1);
    if (nframes == 1) req = 2'b00;
    budget = nframes * 400 + 50;
    cyc = 0;
    while (done_cnt < dn0 + nframes && cyc < budget) begin
      if (throttle) enc_ready = 1'($urandom);
      tick();
      cyc++;
    end
    req = 2'b00;
    enc_ready = 1'b1;
    chk({tag, "_timeout"}, 32'(cyc < budget), 32'd1);
    repeat (3) tick();

    chk({tag, "_bits_len"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) mism++;
    end
    chk({tag, "_bits_mism"}, 32'(mism), 32'd0);
    chk({tag, "_pops0"}, 32'(pops0 - p0), 32'(e_pops0));
    chk({tag, "_pops1"}, 32'(pops1 - p1), 32'(e_pops1));
    chk({tag, "_done_cnt"}, 32'(done_cnt - dn0), 32'(nframes));
    mism = 0;
    for (int i = 0; i < nframes; i++) begin
      if (gb + i >= gnt_done_q.size() || gnt_done_q[gb + i] !== 2'(1 << win[i])) mism++;
    end
    chk({tag, "_gnt_seq"}, 32'(mism), 32'd0);
    if (nframes > 1) begin
      mism = 0;
      for (int i = 1; i < nframes; i++) begin
        if (gpb + i >= gap_q.size() || gap_q[gpb + i] != 2) mism++;
      end
      chk({tag, "_gaps"}, 32'(mism), 32'd0);
    end
    if (!throttle) begin
      mism = 0;
      for (int i = 0; i < nframes; i++) begin
        if (rb + i >= run_q.size() || run_q[rb + i] != runlen[i]) mism++;
      end
      chk({tag, "_runs"}, 32'(mism), 32'd0);
    end
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_data_rd"}, 32'(data_rd), 32'd0);
    chk({tag, "_enc_bit"}, 32'(enc_bit), 32'd0);
    chk({tag, "_enc_valid"}, 32'(enc_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    logic [35:0] v;
    logic [7:0]  lb;
    int          dn0;

    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed frame from the plan: L=2, data A5 3C.
    lc0 = 5'd2;
    mem0[rd_ptr0]        = 8'hA5;
    mem0[rd_ptr0 + 8'd1] = 8'h3C;
    frame_test(2'b01, 1, 1'b0, 1'b0, "basic");
    v = '0;
    for (int i = 0; i < 36; i++) begin
      if (last_base + i < got_q.size()) v[35-i] = got_q[last_base + i];
    end
    chk("basic_stream_hi", v[35:4], 32'hA102A53C);
    chk("basic_stream_lo", 32'(v[3:0]), 32'd0);

    lc0 = 5'd1; lc1 = 5'd1;
    frame_test(2'b11, 4, 1'b0, 1'b1, "alt");

    lc1 = 5'd0;
    frame_test(2'b10, 1, 1'b0, 1'b1, "len0");

    lc0 = 5'd31;
    frame_test(2'b01, 1, 1'b0, 1'b1, "clamp");
    lb = '0;
    for (int i = 0; i < 8; i++) begin
      if (last_base + 8 + i < got_q.size()) lb[7-i] = got_q[last_base + 8 + i];
    end
    chk("clamp_len_byte", 32'(lb), 32'h10);

    lc0 = 5'd4;
    frame_test(2'b01, 1, 1'b1, 1'b1, "throttle");
    chk("throttle_stall_stable", 32'(stall_bad), 32'd0);
    chk("throttle_rd_stall", 32'(rd_stall_bad), 32'd0);

    for (int r = 0; r < 6; r++) begin
      lc0 = 5'($urandom_range(0, 20));
      lc1 = 5'($urandom_range(0, 20));
      frame_test(2'($urandom_range(1, 3)), $urandom_range(1, 3), 1'($urandom), 1'b1, "rand");
    end

    // Reset in the middle of a payload.
    lc0 = 5'd8;
    dn0 = done_cnt;
    req = 2'b01;
    repeat (30) tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    chk_all_zero("abort");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    rr_ptr = 0;
    exp_frames = 8'd0;
    lc0 = 5'd1; lc1 = 5'd1;
    frame_test(2'b11, 2, 1'b0, 1'b1, "post_rst");

    chk("final_stall_stable", 32'(stall_bad), 32'd0);
    chk("final_rd_stall", 32'(rd_stall_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
